// File: rtl/vga_pixel_pipe.sv
// VGA back end: raster counters, PIPE_LAT-deep shader alignment, Bayer-dithered DAC output.
// Define TEMPORAL_DITHER_EN to flip the Bayer column index on odd frames.

module vga_dither_lane #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic [IN_BITS-1:0]  c,
  input  logic [4:0]          bayer,
  output logic [OUT_BITS-1:0] q
);
  localparam int W = IN_BITS + OUT_BITS + 1;

  logic [W-1:0] s;
  logic [W-1:0] sum;

  assign s   = W'(c) * W'((1 << OUT_BITS) - 1);
  assign sum = s + (W'(bayer) << (IN_BITS - 5));
  // The bare formula lands one code short on low-threshold cells, so full scale is pinned to the top code.
  assign q   = (&c) ? '1 : sum[IN_BITS +: OUT_BITS];
endmodule

module vga_pixel_pipe #(
  parameter int   H_DISPLAY = 1220,
  parameter int   H_FRONT   = 31,
  parameter int   H_SYNC    = 183,
  parameter int   H_BACK    = 92,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter int   IN_BITS   = 6,
  parameter int   OUT_BITS  = 2,
  parameter int   PIPE_LAT  = 2,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic                clk48,
  input  logic                rst_n,
  output logic [10:0]         h_count,
  output logic [9:0]          v_count,
  output logic [10:0]         frame,
  output logic                line_start,
  output logic                frame_start,
  output logic                active,
  input  logic [IN_BITS-1:0]  r_in,
  input  logic [IN_BITS-1:0]  g_in,
  input  logic [IN_BITS-1:0]  b_in,
  output logic                hsync,
  output logic                vsync,
  output logic [OUT_BITS-1:0] r_out,
  output logic [OUT_BITS-1:0] g_out,
  output logic [OUT_BITS-1:0] b_out
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO   = H_DISPLAY + H_FRONT;
  localparam int VS_LO   = V_DISPLAY + V_FRONT;

  typedef struct packed {
    logic       act;
    logic       hreq;
    logic       vreq;
    logic [2:0] hl;
    logic [1:0] vl;
    logic       f0;
  } tap_t;

  tap_t tap_now;
  tap_t tap_dly;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
      frame   <= '0;
    end else if (h_count == 11'(H_TOTAL - 1)) begin
      h_count <= '0;
      if (v_count == 10'(V_TOTAL - 1)) begin
        v_count <= '0;
        frame   <= frame + 11'd1;
      end else begin
        v_count <= v_count + 10'd1;
      end
    end else begin
      h_count <= h_count + 11'd1;
    end
  end

  assign line_start  = (h_count == '0);
  assign frame_start = (h_count == '0) && (v_count == '0);
  assign active      = (h_count < 11'(H_DISPLAY)) && (v_count < 10'(V_DISPLAY));

  always_comb begin
    tap_now      = '0;
    tap_now.act  = active;
    tap_now.hreq = (h_count >= 11'(HS_LO)) && (h_count < 11'(HS_LO + H_SYNC));
    tap_now.vreq = (v_count >= 10'(VS_LO)) && (v_count < 10'(VS_LO + V_SYNC));
    tap_now.hl   = h_count[2:0];
    tap_now.vl   = v_count[1:0];
    tap_now.f0   = frame[0];
  end

  // Raster side-band rides alongside the shader so syncs and colour stay aligned.
  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign tap_dly = tap_now;
    end else begin : g_dly
      tap_t [PIPE_LAT-1:0] tap_pipe;
      always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
          tap_pipe <= '0;
        end else begin
          tap_pipe[0] <= tap_now;
          for (int k = 1; k < PIPE_LAT; k++) tap_pipe[k] <= tap_pipe[k-1];
        end
      end
      assign tap_dly = tap_pipe[PIPE_LAT-1];
    end
  endgenerate

  logic [2:0] bi;
  logic [2:0] bx;
  logic [4:0] bayer;

`ifdef TEMPORAL_DITHER_EN
  assign bi = tap_dly.hl ^ {3{tap_dly.f0}};
`else
  logic f0_unused;
  assign f0_unused = tap_dly.f0;
  assign bi = tap_dly.hl;
`endif

  assign bx    = {bi[2], bi[1] ^ tap_dly.vl[1], bi[0] ^ tap_dly.vl[0]};
  assign bayer = {bx[0], bi[0], bx[1], bi[1], bx[2]};

  logic [2:0][IN_BITS-1:0]  col_in;
  logic [2:0][OUT_BITS-1:0] dith;

  assign col_in = {r_in, g_in, b_in};

  vga_dither_lane #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_lane [2:0] (
    .c     (col_in),
    .bayer (bayer),
    .q     (dith)
  );

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
    end else begin
      r_out <= tap_dly.act ? dith[2] : '0;
      g_out <= tap_dly.act ? dith[1] : '0;
      b_out <= tap_dly.act ? dith[0] : '0;
      hsync <= tap_dly.hreq ? HSYNC_POL : ~HSYNC_POL;
      vsync <= tap_dly.vreq ? VSYNC_POL : ~VSYNC_POL;
    end
  end
endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Parametrised VGA back end: generates raster timing (pixel/line/frame counters, sync, blanking), exposes pixel coordinates to an upstream shader with configurable latency, and converts the shader's IN_BITS-per-channel colour into dithered OUT_BITS-per-channel DAC output. It replaces the hard-wired timing and fixed 6→2-bit dither in the demo top level, so that new effects only supply colour and keep the timing and dither path shared.

## Interface
Parameters:
- H_DISPLAY, 1220, active pixels per line
- H_FRONT, 31; H_SYNC, 183; H_BACK, 92: horizontal porch and sync widths in clk48 cycles
- V_DISPLAY, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical widths in lines
- IN_BITS, 6, shader colour width per channel (≥5)
- OUT_BITS, 2, DAC width per channel (1..4)
- PIPE_LAT, 2, shader latency in cycles (0..7)
- HSYNC_POL, 0 and VSYNC_POL, 0: asserted sync level

Ports:
- clk48  in  1  pixel clock
- rst_n  in  1  reset (asynchronous, active-low)
- h_count  out  11  current pixel column
- v_count  out  10  current line
- frame  out  11  frame counter
- line_start  out  1  high while h_count==0
- frame_start  out  1  high while h_count==0 && v_count==0
- active  out  1  h_count<H_DISPLAY && v_count<V_DISPLAY
- r_in, g_in, b_in  in  IN_BITS each  shader colour for the coordinate issued PIPE_LAT cycles earlier
- hsync, vsync  out  1  registered syncs
- r_out, g_out, b_out  out  OUT_BITS each  registered dithered colour

## Operation
- H_TOTAL = sum of the horizontal parameters; V_TOTAL = sum of the vertical parameters.
- h_count increments every cycle and wraps H_TOTAL-1→0. On that wrap v_count increments; v_count wraps V_TOTAL-1→0, and frame increments on the same edge (mod 2048).
- Sync request: h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC). Same form for v.
- Delay line of depth PIPE_LAT carries {active, hsync_req, vsync_req, h[2:0], v[1:0], frame[0]}.
- Bayer index: i = h[2:0] (XOR {3{frame[0]}} when temporal dither is enabled), j = v[1:0], x = {i2, i1^j1, i0^j0}, bayer = {x0, i0, x1, i1, x2} (5 bits).
- Dither per channel: s = c·(2^OUT_BITS−1) at width IN_BITS+OUT_BITS; out = (s + (bayer << (IN_BITS−5))) >> IN_BITS. Full scale maps to 2^OUT_BITS−1, and 0 always maps to 0.
- Outputs register the delayed stage: colour = delayed active ? dither : 0; each sync = request ? POL : ~POL.

## Timing
- Counters, line_start, frame_start and active are combinational from the counter registers (zero latency).
- Coordinate presented at cycle t; r_in/g_in/b_in are sampled at t+PIPE_LAT; the matching colour, hsync and vsync appear on the outputs after the edge ending cycle t+PIPE_LAT. Syncs and colour stay cycle-aligned for every PIPE_LAT.
- PIPE_LAT=0: shader is combinational and the output latency is 1 cycle.
- Reset values: all counters 0, every delay stage inactive, colour outputs 0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- After reset release, outputs are blank for PIPE_LAT+1 cycles, then follow the raster.
- Reset asserted mid-frame clears everything immediately (asynchronously). The next frame starts at h=v=0.
- Frame counter wrap 2047→0 is silent, with no special pulse.

## Configuration
- TEMPORAL_DITHER_EN defined: Bayer column index is XORed with frame[0], so odd frames use the complementary 8×4 half-pattern.
- TEMPORAL_DITHER_EN undefined: i = h[2:0] and the dither pattern is static.

## Test plan
- Small timing (H 8/2/3/3, V 4/1/2/1, PIPE_LAT=0) → hsync low at h=10..12; vsync low for lines 5..6; frame increments every 16·8=128 cycles.
- PIPE_LAT=3, shader drives r_in = h_count[5:0] → r_out for pixel h appears 4 cycles after h_count=h; the hsync edge stays aligned to the colour.
- Constant input 63 → output 3 in every active pixel. Input 0 → 0. Input 32 → values 1 and 2 each on 16 of 32 Bayer cells. Blanking region → 0.
- TEMPORAL_DITHER_EN with input 21 at pixel (0,0) → output differs between frame 0 and frame 1. Without the macro → identical.
- OUT_BITS=1, IN_BITS=8, input 128 → half the cells in an 8×4 block output 1.
- rst_n pulsed low mid-line → all outputs reset asynchronously. After release, h=v=frame=0 and the first valid colour appears PIPE_LAT+1 cycles later.
